// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header inserter/stripper pair:
// FSM states and byte-enable/count conversion helpers.
package axis_hdr_pkg;

  localparam int unsigned KEEP_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_FLUSH
  } hdrState_t;

  function automatic int unsigned keep2cnt(input logic [KEEP_MAX-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < KEEP_MAX; i++)
      if (keep[i]) cnt++;
    return cnt;
  endfunction

  // Byte 0 of a beat sits in the top keep bit, so MSB-aligned enables fill downward.
  function automatic logic [KEEP_MAX-1:0] cnt2keep_msb(input int unsigned cnt,
                                                        input int unsigned bytes);
    logic [KEEP_MAX-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++)
      if (i < bytes && i + cnt >= bytes) keep[i] = 1'b1;
    return keep;
  endfunction

  function automatic logic [KEEP_MAX-1:0] cnt2keep_lsb(input int unsigned cnt);
    logic [KEEP_MAX-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++)
      if (i < cnt) keep[i] = 1'b1;
    return keep;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational merge of a partial carry beat with the next input beat:
// carry bytes stay on top, input bytes fill in below, the overflow becomes the new carry.
module axis_byte_realign
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0] i_carryData,
  input  logic [CNT_WD-1:0]  i_carryCnt,
  input  logic [DATA_WD-1:0] i_beatData,
  input  logic [CNT_WD-1:0]  i_beatCnt,
  output logic [DATA_WD-1:0] o_mergedData,
  output logic [DATA_WD-1:0] o_leftData,
  output logic [CNT_WD:0]    o_totalCnt
);

  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

  logic [CNT_WD-1:0] w_takeCnt;

  assign w_takeCnt    = FULL_CNT - i_carryCnt;
  assign o_mergedData = i_carryData | (i_beatData >> {i_carryCnt, 3'b000});
  assign o_leftData   = i_beatData << {w_takeCnt, 3'b000};
  assign o_totalCnt   = {1'b0, i_carryCnt} + {1'b0, i_beatCnt};

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips the first N bytes of each AXI-Stream packet onto a separate header port
// and re-packs the remaining payload into MSB-aligned beats.
module axi_stream_strip_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    err_short
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

  hdrState_t                 r_state;
  logic [CNT_WD-1:0]         r_stripCnt;
  logic [CNT_WD-1:0]         r_carryCnt;
  logic [DATA_WD-1:0]        r_carry;
  logic [DATA_WD-1:0]        r_dataOut;
  logic [DATA_BYTE_WD-1:0]   r_keepOut;
  logic                      r_validOut;
  logic                      r_lastOut;
  logic [DATA_WD-1:0]        r_dataHdr;
  logic [DATA_BYTE_WD-1:0]   r_keepHdr;
  logic                      r_validHdr;
  logic                      r_errShort;

  logic [DATA_WD-1:0]        w_byteMask;
  logic [DATA_WD-1:0]        w_beatData;
  logic [CNT_WD-1:0]         w_beatCnt;
  logic [CNT_WD-1:0]         w_hdrShift;
  logic                      w_accept;
  logic [DATA_WD-1:0]        w_merged;
  logic [DATA_WD-1:0]        w_left;
  logic [CNT_WD:0]           w_total;
  logic [CNT_WD-1:0]         w_leftCnt;
  logic [DATA_BYTE_WD-1:0]   w_headKeep;
  logic [DATA_BYTE_WD-1:0]   w_totalKeep;
  logic [DATA_BYTE_WD-1:0]   w_carryKeep;

  // Bytes outside keep are zeroed so they never leak into merged beats.
  for (genvar g = 0; g < DATA_BYTE_WD; g++) begin : g_mask
    assign w_byteMask[8*g +: 8] = {8{keep_in[g]}};
  end

  assign w_beatData  = data_in & w_byteMask;
  assign w_beatCnt   = CNT_WD'(keep2cnt(KEEP_MAX'(keep_in)));
  assign w_hdrShift  = FULL_CNT - r_stripCnt;
  assign w_leftCnt   = CNT_WD'(w_total - {1'b0, FULL_CNT});
  assign w_headKeep  = DATA_BYTE_WD'(cnt2keep_msb(32'(w_beatCnt - r_stripCnt), DATA_BYTE_WD));
  assign w_totalKeep = DATA_BYTE_WD'(cnt2keep_msb(32'(w_total), DATA_BYTE_WD));
  assign w_carryKeep = DATA_BYTE_WD'(cnt2keep_msb(32'(r_carryCnt), DATA_BYTE_WD));

  assign ready_in    = (r_state == ST_HEAD || r_state == ST_BODY) &&
                       (!r_validOut || ready_out) && !(r_validHdr && !ready_hdr);
  assign ready_strip = (r_state == ST_IDLE) && !r_validOut && !r_validHdr;
  assign w_accept    = valid_in && ready_in;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_WD       (CNT_WD)
  ) u_realign (
    .i_carryData  (r_carry),
    .i_carryCnt   (r_carryCnt),
    .i_beatData   (w_beatData),
    .i_beatCnt    (w_beatCnt),
    .o_mergedData (w_merged),
    .o_leftData   (w_left),
    .o_totalCnt   (w_total)
  );

  // Carry count in BODY stays at DW-N (0 for N=0 or N=DW, i.e. pass-through).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_stripCnt <= '0;
      r_carryCnt <= '0;
      r_carry    <= '0;
      r_dataOut  <= '0;
      r_keepOut  <= '0;
      r_validOut <= 1'b0;
      r_lastOut  <= 1'b0;
      r_dataHdr  <= '0;
      r_keepHdr  <= '0;
      r_validHdr <= 1'b0;
      r_errShort <= 1'b0;
    end else begin
      r_errShort <= 1'b0;
      if (r_validOut && ready_out) r_validOut <= 1'b0;
      if (r_validHdr && ready_hdr) r_validHdr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_strip && ready_strip) begin
            r_stripCnt <= byte_strip_cnt;
            r_state    <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (w_accept) begin
            if (r_stripCnt != '0) begin
              r_validHdr <= 1'b1;
              r_dataHdr  <= w_beatData >> {w_hdrShift, 3'b000};
              r_keepHdr  <= keep_in >> w_hdrShift;
            end
            if (last_in) begin
              r_state <= ST_IDLE;
              if (w_beatCnt < r_stripCnt) begin
                r_errShort <= 1'b1;
              end else if (w_beatCnt > r_stripCnt) begin
                r_validOut <= 1'b1;
                r_dataOut  <= w_beatData << {r_stripCnt, 3'b000};
                r_keepOut  <= w_headKeep;
                r_lastOut  <= 1'b1;
              end
            end else if (r_stripCnt == '0) begin
              r_validOut <= 1'b1;
              r_dataOut  <= w_beatData;
              r_keepOut  <= keep_in;
              r_lastOut  <= 1'b0;
              r_carry    <= '0;
              r_carryCnt <= '0;
              r_state    <= ST_BODY;
            end else begin
              r_carry    <= w_beatData << {r_stripCnt, 3'b000};
              r_carryCnt <= w_hdrShift;
              r_state    <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (w_accept) begin
            r_validOut <= 1'b1;
            r_dataOut  <= w_merged;
            if (last_in && w_total <= {1'b0, FULL_CNT}) begin
              r_keepOut <= w_totalKeep;
              r_lastOut <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_keepOut  <= '1;
              r_lastOut  <= 1'b0;
              r_carry    <= w_left;
              r_carryCnt <= w_leftCnt;
              r_state    <= last_in ? ST_FLUSH : ST_BODY;
            end
          end
        end
        ST_FLUSH: begin
          if (!r_validOut || ready_out) begin
            r_validOut <= 1'b1;
            r_dataOut  <= r_carry;
            r_keepOut  <= w_carryKeep;
            r_lastOut  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign valid_out = r_validOut;
  assign data_out  = r_dataOut;
  assign keep_out  = r_keepOut;
  assign last_out  = r_lastOut;
  assign valid_hdr = r_validHdr;
  assign data_hdr  = r_dataHdr;
  assign keep_hdr  = r_keepHdr;
  assign err_short = r_errShort;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench: packets are described as byte lists; the expected header,
// payload beats and short-packet errors are derived from those lists directly.
module tb_axi_stream_strip_header;

  localparam int NB = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;
  typedef logic [7:0] byteQ_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_strip = 1'b0;
  logic [2:0]  byte_strip_cnt = '0;
  logic        ready_strip;
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        err_short;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int inStalls = 0;
  int lastInCyc = 0;
  int lastOutCyc = 0;
  int outLow = 0;
  int hdrLow = 0;
  int pOut = 100;
  int pHdr = 100;

  beat_t expOutQ[$];
  beat_t expHdrQ[$];
  int    expErr = 0;
  beat_t modelOut[$];
  beat_t modelHdr[$];
  int    modelErr;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_strip    (valid_strip),
    .byte_strip_cnt (byte_strip_cnt),
    .ready_strip    (ready_strip),
    .valid_hdr      (valid_hdr),
    .data_hdr       (data_hdr),
    .keep_hdr       (keep_hdr),
    .ready_hdr      (ready_hdr),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .err_short      (err_short)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness: forced-low windows first, otherwise random with a percentage.
  always @(posedge clk) begin
    #2;
    if (outLow > 0) begin
      ready_out = 1'b0;
      outLow--;
    end else begin
      ready_out = ($urandom_range(0, 99) < pOut);
    end
    if (hdrLow > 0) begin
      ready_hdr = 1'b0;
      hdrLow--;
    end else begin
      ready_hdr = ($urandom_range(0, 99) < pHdr);
    end
  end

  function automatic logic [31:0] keepMask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [3:0] msbKeep(input int c);
    logic [3:0] k;
    for (int i = 0; i < NB; i++) k[NB-1-i] = (i < c);
    return k;
  endfunction

  function automatic byteQ_t seqBytes(input int count);
    byteQ_t q;
    for (int i = 0; i < count; i++) q.push_back(8'(8'hA0 + 16 * (i / 4) + i % 4));
    return q;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    tests++;
    fails++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Reference model: header = first N bytes right-aligned, payload = rest in full beats.
  task automatic buildExpect(input int n, input byteQ_t b);
    int L;
    beat_t hb;
    beat_t ob;
    L = b.size();
    modelOut.delete();
    modelHdr.delete();
    modelErr = (L < n) ? 1 : 0;
    if (n > 0) begin
      hb.data = '0;
      hb.keep = '0;
      hb.last = 1'b0;
      for (int i = 0; i < n && i < L; i++) begin
        int p;
        p = NB - n + i;
        hb.data[8*(NB-1-p) +: 8] = b[i];
        hb.keep[NB-1-p] = 1'b1;
      end
      modelHdr.push_back(hb);
    end
    for (int s = n; s < L; s += NB) begin
      int cnt;
      cnt = (L - s < NB) ? L - s : NB;
      ob.data = '0;
      for (int j = 0; j < cnt; j++) ob.data[8*(NB-1-j) +: 8] = b[s+j];
      ob.keep = msbKeep(cnt);
      ob.last = (s + NB >= L);
      modelOut.push_back(ob);
    end
  endtask

  task automatic applyStimulus(input int n, input byteQ_t b, input int abortAt,
                               input bit gaps, input int stallAt);
    int L;
    int nb;
    bit hs;
    int budget;
    L  = b.size();
    nb = (L + NB - 1) / NB;
    buildExpect(n, b);
    foreach (modelHdr[i]) expHdrQ.push_back(modelHdr[i]);
    foreach (modelOut[i]) expOutQ.push_back(modelOut[i]);
    expErr += modelErr;
    valid_strip    = 1'b1;
    byte_strip_cnt = 3'(n);
    hs = 1'b0;
    budget = 0;
    while (!hs && budget < 1000) begin
      @(negedge clk);
      hs = ready_strip;
      @(posedge clk);
      #1;
      budget++;
    end
    valid_strip    = 1'b0;
    byte_strip_cnt = '0;
    checkOutput("cmdAccepted", 64'(hs), 64'd1);
    if (!hs) return;
    if (stallAt >= 0) hdrLow = 2;
    for (int k = 0; k < nb; k++) begin
      int c;
      logic [31:0] d;
      if (k == abortAt) break;
      if (gaps) begin
        valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      c = (L - k * NB < NB) ? L - k * NB : NB;
      d = $urandom;
      for (int j = 0; j < c; j++) d[8*(NB-1-j) +: 8] = b[k*NB+j];
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = msbKeep(c);
      last_in  = (k == nb - 1);
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 1000) begin
        @(negedge clk);
        hs = ready_in;
        if (hs) lastInCyc = cyc;
        else inStalls++;
        @(posedge clk);
        #1;
        budget++;
      end
      checkOutput("beatAccepted", 64'(hs), 64'd1);
      if (k == stallAt) outLow = 3;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((expOutQ.size() != 0 || expHdrQ.size() != 0 || expErr != 0) && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("drainOut", 64'(expOutQ.size()), 64'd0);
    checkOutput("drainHdr", 64'(expHdrQ.size()), 64'd0);
    checkOutput("drainErr", 64'(expErr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rstValidOut", 64'(valid_out), 64'd0);
    checkOutput("rstDataOut", 64'(data_out), 64'd0);
    checkOutput("rstKeepOut", 64'(keep_out), 64'd0);
    checkOutput("rstLastOut", 64'(last_out), 64'd0);
    checkOutput("rstValidHdr", 64'(valid_hdr), 64'd0);
    checkOutput("rstDataHdr", 64'(data_hdr), 64'd0);
    checkOutput("rstKeepHdr", 64'(keep_hdr), 64'd0);
    checkOutput("rstErr", 64'(err_short), 64'd0);
    checkOutput("rstReadyIn", 64'(ready_in), 64'd0);
    checkOutput("rstReadyStrip", 64'(ready_strip), 64'd1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    valid_strip = 1'b0;
    last_in     = 1'b0;
    #1;
    checkResetValues();
    expOutQ.delete();
    expHdrQ.delete();
    expErr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare process: every handshaken beat against the model queues, plus hold/ready rules.
  logic  pendOut = 1'b0;
  logic  pendHdr = 1'b0;
  logic  prevErr = 1'b0;
  beat_t prevOut;
  beat_t prevHdr;
  beat_t eo;
  beat_t eh;

  always @(negedge clk) begin
    if (!rst_n) begin
      pendOut = 1'b0;
      pendHdr = 1'b0;
      prevErr = 1'b0;
    end else begin
      if (pendOut)
        checkOutput("holdOut", {27'd0, valid_out, last_out, keep_out, data_out},
                    {27'd0, 1'b1, prevOut.last, prevOut.keep, prevOut.data});
      if (pendHdr)
        checkOutput("holdHdr", {28'd0, valid_hdr, keep_hdr, data_hdr},
                    {28'd0, 1'b1, prevHdr.keep, prevHdr.data});
      if ((valid_out && !ready_out) || (valid_hdr && !ready_hdr))
        checkOutput("readyInBlocked", 64'(ready_in), 64'd0);
      if (valid_out && ready_out) begin
        if (expOutQ.size() == 0) begin
          reportFail("unexpectedOut", $sformatf("got beat %h/%b", data_out, keep_out));
        end else begin
          eo = expOutQ.pop_front();
          checkOutput("outKeep", 64'(keep_out), 64'(eo.keep));
          checkOutput("outLast", 64'(last_out), 64'(eo.last));
          checkOutput("outData", 64'(data_out & keepMask(eo.keep)), 64'(eo.data));
          if (last_out) lastOutCyc = cyc;
        end
      end
      if (valid_hdr && ready_hdr) begin
        if (expHdrQ.size() == 0) begin
          reportFail("unexpectedHdr", $sformatf("got header %h/%b", data_hdr, keep_hdr));
        end else begin
          eh = expHdrQ.pop_front();
          checkOutput("hdrKeep", 64'(keep_hdr), 64'(eh.keep));
          checkOutput("hdrData", 64'(data_hdr & keepMask(eh.keep)), 64'(eh.data));
        end
      end
      if (err_short) begin
        if (expErr == 0) reportFail("unexpectedErr", "err_short pulsed with no short packet");
        else begin
          expErr--;
          checkOutput("errPulseWidth", 64'(prevErr), 64'd0);
        end
      end
      prevErr = err_short;
      pendOut = valid_out && !ready_out;
      prevOut = '{data: data_out, keep: keep_out, last: last_out};
      pendHdr = valid_hdr && !ready_hdr;
      prevHdr = '{data: data_hdr, keep: keep_hdr, last: 1'b0};
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byteQ_t pk;
    #2 rst_n = 1'b0;
    #1 checkResetValues();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // N=2, three full beats: payload realigned, final beat goes through FLUSH.
    pk = seqBytes(12);
    buildExpect(2, pk);
    checkOutput("pinN2Sizes", {32'(modelHdr.size()), 32'(modelOut.size())}, {32'd1, 32'd3});
    if (modelOut.size() == 3 && modelHdr.size() == 1) begin
      checkOutput("pinN2Hdr", {28'(modelHdr[0].keep), modelHdr[0].data}, {28'h3, 32'h0000A0A1});
      checkOutput("pinN2Out0", {27'(modelOut[0].last), modelOut[0].keep, modelOut[0].data}, {27'd0, 4'hF, 32'hA2A3B0B1});
      checkOutput("pinN2Out1", {27'(modelOut[1].last), modelOut[1].keep, modelOut[1].data}, {27'd0, 4'hF, 32'hB2B3C0C1});
      checkOutput("pinN2Out2", {27'(modelOut[2].last), modelOut[2].keep, modelOut[2].data}, {27'd1, 4'hC, 32'hC2C30000});
    end
    inStalls = 0;
    applyStimulus(2, pk, -1, 1'b0, -1);
    drain();
    checkOutput("n2NoInputStall", 64'(inStalls), 64'd0);

    // N=1, second beat holds one byte: single merged final beat, no flush cycle.
    pk = seqBytes(5);
    buildExpect(1, pk);
    checkOutput("pinN1Sizes", {32'(modelHdr.size()), 32'(modelOut.size())}, {32'd1, 32'd1});
    if (modelOut.size() == 1)
      checkOutput("pinN1Out", {27'(modelOut[0].last), modelOut[0].keep, modelOut[0].data}, {27'd1, 4'hF, 32'hA1A2A3B0});
    applyStimulus(1, pk, -1, 1'b0, -1);
    drain();
    checkOutput("n1Latency", 64'(lastOutCyc - lastInCyc), 64'd1);

    // N=4: whole first beat is header; N=0: packet passes unchanged.
    pk = seqBytes(7);
    buildExpect(4, pk);
    if (modelHdr.size() == 1 && modelOut.size() == 1) begin
      checkOutput("pinN4Hdr", {28'(modelHdr[0].keep), modelHdr[0].data}, {28'hF, 32'hA0A1A2A3});
      checkOutput("pinN4Out", {27'(modelOut[0].last), modelOut[0].keep, modelOut[0].data}, {27'd1, 4'hE, 32'hB0B1B200});
    end else begin
      reportFail("pinN4Sizes", "model produced wrong beat counts");
    end
    applyStimulus(4, pk, -1, 1'b0, -1);
    drain();
    buildExpect(0, pk);
    checkOutput("pinN0Sizes", {32'(modelHdr.size()), 32'(modelOut.size())}, {32'd0, 32'd2});
    inStalls = 0;
    applyStimulus(0, pk, -1, 1'b0, -1);
    drain();
    checkOutput("n0NoInputStall", 64'(inStalls), 64'd0);

    // N=3 with a one-byte packet: short header, error pulse, no payload.
    pk = seqBytes(1);
    buildExpect(3, pk);
    checkOutput("pinShortErr", {32'(modelErr), 32'(modelOut.size())}, {32'd1, 32'd0});
    if (modelHdr.size() == 1)
      checkOutput("pinShortHdr", {28'(modelHdr[0].keep), modelHdr[0].data}, {28'h4, 32'h00A00000});
    applyStimulus(3, pk, -1, 1'b0, -1);
    drain();

    // Backpressure on both output ports mid-packet.
    pk.delete();
    for (int i = 0; i < 16; i++) pk.push_back(8'($urandom));
    applyStimulus(2, pk, -1, 1'b0, 1);
    drain();

    // Reset in the middle of a packet, then a clean N=2 packet.
    pk.delete();
    for (int i = 0; i < 20; i++) pk.push_back(8'($urandom));
    applyStimulus(2, pk, 3, 1'b0, -1);
    doReset();
    pk = seqBytes(12);
    applyStimulus(2, pk, -1, 1'b0, -1);
    drain();

    // Randomized packets, strip counts and readiness.
    pOut = 70;
    pHdr = 60;
    for (int p = 0; p < 60; p++) begin
      int n;
      int L;
      n = $urandom_range(0, 4);
      L = $urandom_range(1, 14);
      pk.delete();
      for (int i = 0; i < L; i++) pk.push_back(8'($urandom));
      applyStimulus(n, pk, -1, 1'b1, -1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
